// File: rtl/cam_frame_capture.sv
// OV7670-style parallel camera receiver. It samples the camera bus in the clk domain,
// pairs up RGB565 bytes and writes RGB444 pixels to a linear frame-buffer address.
module cam_frame_capture #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_PCLK,
    input  logic          CAM_VSYNC,
    input  logic          CAM_HREF,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          frame_err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {WAIT_VS, VS_HI, BYTE1, BYTE2, DONE} state_t;

    state_t        state_q, state_d;
    logic          pclk_r1_q, pclk_r2_q, vsync_r1_q, href_r1_q;
    logic [7:0]    data_r1_q;
    logic [6:0]    b1_q, b1_d;          // byte1 minus bit 3, which RGB444 drops
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] pix_q, pix_d;
    logic          wr_q, wr_d, done_q, done_d, err_q, err_d;
    logic          pclk_rise;

    assign pclk_rise = pclk_r1_q & ~pclk_r2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_r1_q  <= 1'b0;
            pclk_r2_q  <= 1'b0;
            vsync_r1_q <= 1'b0;
            href_r1_q  <= 1'b0;
            data_r1_q  <= '0;
            state_q    <= WAIT_VS;
            b1_q       <= '0;
            addr_q     <= '0;
            pix_q      <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pclk_r1_q  <= CAM_PCLK;
            pclk_r2_q  <= pclk_r1_q;
            vsync_r1_q <= CAM_VSYNC;
            href_r1_q  <= CAM_HREF;
            data_r1_q  <= CAM_px_data;
            state_q    <= state_d;
            b1_q       <= b1_d;
            addr_q     <= addr_d;
            pix_q      <= pix_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b1_d    = b1_q;
        addr_d  = addr_q;
        pix_d   = pix_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // Address advances once the write has been presented; the last address sticks.
        if (wr_q && addr_q != LAST_ADDR)
            addr_d = addr_q + 1'b1;

        if (pclk_rise) begin
            unique case (state_q)
                WAIT_VS: if (vsync_r1_q) state_d = VS_HI;
                VS_HI: if (!vsync_r1_q) begin
                    state_d = BYTE1;
                    addr_d  = '0;
                end
                BYTE1: begin
                    if (vsync_r1_q) begin
                        err_d   = 1'b1;
                        state_d = VS_HI;
                    end else if (href_r1_q) begin
                        b1_d    = {data_r1_q[7:4], data_r1_q[2:0]};
                        state_d = BYTE2;
                    end
                end
                BYTE2: begin
                    if (vsync_r1_q) begin
                        err_d   = 1'b1;
                        state_d = VS_HI;
                    end else if (href_r1_q) begin
                        wr_d    = 1'b1;
                        pix_d   = {b1_q[6:3], b1_q[2:0], data_r1_q[7], data_r1_q[4:1]};
                        done_d  = (addr_q == LAST_ADDR);
                        state_d = (addr_q == LAST_ADDR) ? DONE : BYTE1;
                    end else begin
                        // Line ended between the two bytes of a pixel.
                        err_d   = 1'b1;
                        state_d = BYTE1;
                    end
                end
                DONE: if (vsync_r1_q) state_d = VS_HI;
                default: state_d = WAIT_VS;
            endcase
        end
    end

    assign mem_px_addr = addr_q;
    assign mem_px_data = pix_q;
    assign px_wr       = wr_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Randomized bench for cam_frame_capture: an event-level camera model predicts writes and errors,
// and a monitor compares every DUT strobe against the predicted queue.
module tb_cam_frame_capture;
    localparam int W = 16, H = 8, N = W * H, AW = 15, DW = 12;

    logic clk = 1'b0;
    logic rst, CAM_PCLK, CAM_VSYNC, CAM_HREF;
    logic [7:0] CAM_px_data;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic px_wr, frame_done, frame_err;

    cam_frame_capture #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .CAM_PCLK(CAM_PCLK), .CAM_VSYNC(CAM_VSYNC),
        .CAM_HREF(CAM_HREF), .CAM_px_data(CAM_px_data), .mem_px_addr(mem_px_addr),
        .mem_px_data(mem_px_data), .px_wr(px_wr), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {bit err; int addr; int data; bit done; int t;} ev_t;
    ev_t q[$];
    int tests = 0, fails = 0, n_wr = 0, n_done = 0, n_err = 0;

    // Camera model: armed after a VSYNC high, capturing after VSYNC drops.
    bit m_seen, m_cap, m_hb1;
    int m_addr;
    bit [7:0] m_b1;

    function automatic void model_reset();
        m_seen = 0; m_cap = 0; m_hb1 = 0; m_addr = 0;
    endfunction

    function automatic void model(input bit v, input bit h, input bit [7:0] dd, input int t0);
        ev_t e;
        e.err = 0; e.addr = 0; e.data = 0; e.done = 0; e.t = t0 + 2;
        if (!m_cap) begin
            if (v) m_seen = 1;
            else if (m_seen) begin m_cap = 1; m_addr = 0; m_hb1 = 0; end
        end else if (v) begin
            e.err = 1; q.push_back(e);
            m_cap = 0; m_seen = 1; m_hb1 = 0;
        end else if (h) begin
            if (!m_hb1) begin m_b1 = dd; m_hb1 = 1; end
            else begin
                e.addr = m_addr;
                e.data = (m_b1 >> 4) * 256 + (m_b1 % 8) * 32 + (dd >> 7) * 16 + (dd >> 1) % 16;
                e.done = (m_addr == N - 1);
                q.push_back(e);
                m_hb1 = 0;
                if (m_addr == N - 1) begin m_cap = 0; m_seen = 0; end
                else m_addr++;
            end
        end else if (m_hb1) begin
            e.err = 1; q.push_back(e); m_hb1 = 0;
        end
    endfunction

    // One PCLK period (2 clk high, 2 low); called at a negedge.
    task automatic pclk_cycle(input bit v, input bit h, input bit [7:0] dd);
        CAM_PCLK = 1; CAM_VSYNC = v; CAM_HREF = h; CAM_px_data = dd;
        if (!rst) model(v, h, dd, cyc);
        repeat (2) @(negedge clk);
        CAM_PCLK = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic new_frame();
        repeat (2) pclk_cycle(1, 0, 8'h00);
        pclk_cycle(0, 0, 8'h00);
    endtask

    task automatic send_pair(input bit [7:0] a, input bit [7:0] b);
        pclk_cycle(0, 1, a);
        pclk_cycle(0, 1, b);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " addr"}, int'(mem_px_addr), 0);
        check({name, " data"}, int'(mem_px_data), 0);
        check({name, " strobes"}, {px_wr, frame_done, frame_err}, 0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (px_wr) n_wr++;
        if (frame_done) n_done++;
        if (frame_err) n_err++;
        if (frame_done && !px_wr) begin
            tests++; fails++;
            $display("FAIL done_without_wr at cyc %0d", cyc);
        end
        if (px_wr || frame_err) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: wr=%0b err=%0b addr=%0h data=%0h, none expected",
                         px_wr, frame_err, mem_px_addr, mem_px_data);
            end else begin
                e = q.pop_front();
                if (frame_err != e.err || px_wr != !e.err || cyc != e.t ||
                    (!e.err && (int'(mem_px_addr) != e.addr || int'(mem_px_data) != e.data ||
                                frame_done != e.done))) begin
                    fails++;
                    $display("FAIL event: got wr=%0b err=%0b addr=%0h data=%0h done=%0b cyc=%0d; expected err=%0b addr=%0h data=%0h done=%0b cyc=%0d",
                             px_wr, frame_err, mem_px_addr, mem_px_data, frame_done, cyc,
                             e.err, e.addr, e.data, e.done, e.t);
                end
            end
        end
    end

    initial begin
        rst = 1; CAM_PCLK = 0; CAM_VSYNC = 0; CAM_HREF = 0; CAM_px_data = 0;
        model_reset();
        @(negedge clk);
        // Reset held ~20 clk with the bus active, then no capture without VSYNC.
        for (int i = 0; i < 5; i++) pclk_cycle(0, i[0], 8'($urandom));
        check_zero("reset");
        rst = 0;
        for (int i = 0; i < 10; i++) pclk_cycle(0, i[0], 8'($urandom));

        new_frame();
        send_pair(8'hE0, 8'h00);
        new_frame();
        send_pair(8'h07, 8'hE0);
        send_pair(8'h00, 8'h1F);
        // Line breaks mid-pixel, then plain idle HREF low.
        pclk_cycle(0, 1, 8'hAB);
        pclk_cycle(0, 0, 8'h00);
        pclk_cycle(0, 0, 8'h00);
        send_pair(8'h5A, 8'hC3);

        // Full frame with random idle gaps, then surplus bytes to be discarded.
        new_frame();
        n_wr = 0; n_done = 0; n_err = 0;
        for (int p = 0; p < N; p++) begin
            repeat ($urandom_range(0, 2)) pclk_cycle(0, 0, 8'($urandom));
            send_pair(8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 3; i++) send_pair(8'($urandom), 8'($urandom));
        repeat (4) @(negedge clk);
        check("frame writes", n_wr, N);
        check("frame_done count", n_done, 1);
        check("frame_err count", n_err, 0);
        check("last addr", int'(mem_px_addr), N - 1);

        // Short frame: VSYNC after a few lines, next frame restarts at 0.
        new_frame();
        for (int p = 0; p < 2 * W + 5; p++) send_pair(8'($urandom), 8'($urandom));
        pclk_cycle(0, 1, 8'h11);
        new_frame();
        send_pair(8'hFF, 8'hFF);
        send_pair(8'h12, 8'h34);

        // Reset mid-line.
        pclk_cycle(0, 1, 8'h77);
        rst = 1;
        @(negedge clk);
        check_zero("mid reset");
        rst = 0;
        model_reset();
        for (int i = 0; i < 6; i++) send_pair(8'($urandom), 8'($urandom));
        new_frame();
        send_pair(8'h9C, 8'h6E);

        // Random frames with random line breaks.
        for (int f = 0; f < 4; f++) begin
            new_frame();
            for (int i = 0; i < 40; i++) begin
                int r = $urandom_range(0, 9);
                if (r == 0) pclk_cycle(0, 0, 8'($urandom));
                else if (r == 1) begin pclk_cycle(0, 1, 8'($urandom)); pclk_cycle(0, 0, 8'h00); end
                else send_pair(8'($urandom), 8'($urandom));
            end
        end
        new_frame();
        repeat (8) @(negedge clk);
        check("pending events", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
